move_checker: RTL and testbench

- Checks whether the current player may place a piece at cursor (x, y) on the 8x8 Reversi board.
- Walks all eight directions one cell per cycle and builds a 64-bit mask of the opponent pieces that the move would flip.
- Sits directly upstream of the place/flip stage in the datapath, and is sequenced by the control FSM through the check-valid-move enable/go handshake.
- Its flip mask and valid flag are consumed by the flip stage and by control.

---
 rtl/move_checker_if.sv | 29 ++
 rtl/move_checker.sv | 185 ++++++++++++++++++
 tb/tb_move_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/move_checker_if.sv
// Handshake and data bundle between the control FSM and the Reversi move checker.
// The control side drives the request; the checker returns done, validity and the flip mask.
`timescale 1ns/1ps
interface move_checker_if #(
  parameter int BOARD_DIM = 8
);
  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int CW    = $clog2(BOARD_DIM);

  logic               check_en;
  logic [2*CELLS-1:0] board;
  logic [CW-1:0]      cur_x;
  logic [CW-1:0]      cur_y;
  logic               player;
  logic               done;
  logic               valid_move;
  logic [CELLS-1:0]   flip_mask;
  logic [CW*2-1:0]    flip_count;

  modport master (
    output check_en, board, cur_x, cur_y, player,
    input  done, valid_move, flip_mask, flip_count
  );

  modport slave (
    input  check_en, board, cur_x, cur_y, player,
    output done, valid_move, flip_mask, flip_count
  );
endinterface

// File: rtl/move_checker.sv
// Reversi legal-move checker: walks the eight rays from the cursor one cell per cycle
// and accumulates the opponent pieces bracketed by the current player's own pieces.
`timescale 1ns/1ps
module move_checker #(
  parameter int BOARD_DIM = 8
) (
  input  logic          clk,
  input  logic          resetn,
  move_checker_if.slave chk
);
  localparam int CELLS = BOARD_DIM * BOARD_DIM;

  typedef enum logic [2:0] {IDLE, ORIGIN, SCAN, NEXT_DIR, FINISH} state_t;

  state_t               state_q, state_d;
  logic [2*CELLS-1:0]   board_q;
  logic [2:0]           ox_q, ox_d, oy_q, oy_d;
  logic                 player_q, player_d;
  logic [2:0]           dir_q, dir_d;
  logic signed [3:0]    px_q, px_d, py_q, py_d;
  logic [CELLS-1:0]     temp_q, temp_d;
  logic [CELLS-1:0]     flip_mask_q, flip_mask_d;
  logic [5:0]           flip_count_q, flip_count_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  // Ray order E, NE, N, NW, W, SW, S, SE with y growing downward.
  function automatic logic signed [3:0] delta_x(input logic [2:0] dir);
    case (dir)
      3'd0, 3'd1, 3'd7: delta_x = 4'sd1;
      3'd3, 3'd4, 3'd5: delta_x = -4'sd1;
      default:          delta_x = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] delta_y(input logic [2:0] dir);
    case (dir)
      3'd1, 3'd2, 3'd3: delta_y = -4'sd1;
      3'd5, 3'd6, 3'd7: delta_y = 4'sd1;
      default:          delta_y = 4'sd0;
    endcase
  endfunction

  function automatic logic [5:0] popcount(input logic [CELLS-1:0] m);
    popcount = '0;
    for (int i = 0; i < CELLS; i++) popcount = popcount + 6'(m[i]);
  endfunction

  logic [5:0] origin_idx, pos_idx;
  logic [1:0] origin_cell, pos_cell, own_code, opp_code;
  logic       pos_oob;

  assign origin_idx  = {oy_q, ox_q};
  assign pos_idx     = {py_q[2:0], px_q[2:0]};
  assign origin_cell = board_q[{origin_idx, 1'b0} +: 2];
  assign pos_cell    = board_q[{pos_idx, 1'b0} +: 2];
  // Coordinates span -1..8, so bit 3 is set exactly when a step left the board.
  assign pos_oob     = px_q[3] | py_q[3];
  assign own_code    = player_q ? 2'b10 : 2'b01;
  assign opp_code    = player_q ? 2'b01 : 2'b10;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    player_d     = player_q;
    dir_d        = dir_q;
    px_d         = px_q;
    py_d         = py_q;
    temp_d       = temp_q;
    flip_mask_d  = flip_mask_q;
    flip_count_d = flip_count_q;
    valid_d      = valid_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (chk.check_en) begin
          ox_d         = chk.cur_x;
          oy_d         = chk.cur_y;
          player_d     = chk.player;
          flip_mask_d  = '0;
          flip_count_d = '0;
          valid_d      = 1'b0;
          state_d      = ORIGIN;
        end
      end
      ORIGIN: begin
        if (^origin_cell) begin
          state_d = FINISH;
        end else begin
          dir_d   = 3'd0;
          px_d    = $signed({1'b0, ox_q}) + delta_x(3'd0);
          py_d    = $signed({1'b0, oy_q}) + delta_y(3'd0);
          temp_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        state_d = NEXT_DIR;
        temp_d  = '0;
        if (!pos_oob && pos_cell == opp_code) begin
          temp_d  = temp_q | (CELLS'(1) << pos_idx);
          px_d    = px_q + delta_x(dir_q);
          py_d    = py_q + delta_y(dir_q);
          state_d = SCAN;
        end else if (!pos_oob && pos_cell == own_code) begin
          flip_mask_d = flip_mask_q | temp_q;
        end
      end
      NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          state_d = FINISH;
        end else begin
          dir_d   = dir_q + 3'd1;
          px_d    = $signed({1'b0, ox_q}) + delta_x(dir_q + 3'd1);
          py_d    = $signed({1'b0, oy_q}) + delta_y(dir_q + 3'd1);
          temp_d  = '0;
          state_d = SCAN;
        end
      end
      FINISH: begin
        if (chk.check_en) begin
          done_d       = 1'b1;
          flip_count_d = popcount(flip_mask_q);
          valid_d      = |flip_mask_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Losing the enable mid-check abandons the result entirely.
    if (!chk.check_en && state_q inside {ORIGIN, SCAN, NEXT_DIR}) begin
      state_d      = IDLE;
      flip_mask_d  = '0;
      flip_count_d = '0;
      valid_d      = 1'b0;
      done_d       = 1'b0;
    end
  end

  // NOTE: the board snapshot is only read after being loaded, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && chk.check_en) board_q <= chk.board;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ox_q         <= '0;
      oy_q         <= '0;
      player_q     <= 1'b0;
      dir_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      temp_q       <= '0;
      flip_mask_q  <= '0;
      flip_count_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      player_q     <= player_d;
      dir_q        <= dir_d;
      px_q         <= px_d;
      py_q         <= py_d;
      temp_q       <= temp_d;
      flip_mask_q  <= flip_mask_d;
      flip_count_q <= flip_count_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
    end
  end

  assign chk.done       = done_q;
  assign chk.valid_move = valid_q;
  assign chk.flip_mask  = flip_mask_q;
  assign chk.flip_count = flip_count_q;
endmodule

// File: tb/tb_move_checker.sv
// Directed bench for move_checker: hand-built boards with hand-computed flip masks,
// plus latency, abort, hold and asynchronous-reset scenarios.
`timescale 1ns/1ps
module tb_move_checker;
  localparam logic [1:0] EMP = 2'b00, WHT = 2'b01, BLK = 2'b10, BAD = 2'b11;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  move_checker_if mc_if ();
  move_checker dut (.clk(clk), .resetn(resetn), .chk(mc_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int x, input int y,
                                       input logic [1:0] v);
    b[2*(y*8+x) +: 2] = v;
    return b;
  endfunction

  task automatic start_check(input logic [127:0] brd, input int x, input int y, input logic p);
    @(negedge clk);
    mc_if.board    = brd;
    mc_if.cur_x    = 3'(x);
    mc_if.cur_y    = 3'(y);
    mc_if.player   = p;
    mc_if.check_en = 1'b1;
  endtask

  // Returns the number of rising edges until done; the live board is scrambled after
  // the first edge so only the latched copy can produce the right answer.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) mc_if.board = '0;
      if (mc_if.done) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic finish_check(input string tag, input logic [63:0] exp_mask,
                              input logic [5:0] exp_cnt);
    check({tag, "_valid"}, 64'(mc_if.valid_move), 64'(exp_mask != 0));
    check({tag, "_mask"},  mc_if.flip_mask,        exp_mask);
    check({tag, "_count"}, 64'(mc_if.flip_count),  64'(exp_cnt));
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, 64'(mc_if.done), 64'd1);
    mc_if.check_en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, 64'(mc_if.done), 64'd0);
    check({tag, "_mask_kept"}, mc_if.flip_mask, exp_mask);
  endtask

  task automatic run_case(input string tag, input logic [127:0] brd, input int x, input int y,
                          input logic p, input logic [63:0] exp_mask, input logic [5:0] exp_cnt);
    int cyc;
    start_check(brd, x, y, p);
    wait_done(tag, cyc);
    finish_check(tag, exp_mask, exp_cnt);
  endtask

  logic [127:0] start_b, b;
  int cyc;

  initial begin
    resetn         = 1'b0;
    mc_if.check_en = 1'b0;
    mc_if.board    = '0;
    mc_if.cur_x    = '0;
    mc_if.cur_y    = '0;
    mc_if.player   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",  64'(mc_if.done), 64'd0);
    check("rst_valid", 64'(mc_if.valid_move), 64'd0);
    check("rst_mask",  mc_if.flip_mask, 64'd0);
    check("rst_count", 64'(mc_if.flip_count), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    start_b = '0;
    start_b = put(start_b, 3, 3, WHT);
    start_b = put(start_b, 4, 4, WHT);
    start_b = put(start_b, 4, 3, BLK);
    start_b = put(start_b, 3, 4, BLK);

    run_case("open_black", start_b, 2, 3, 1'b1, 64'd1 << 27, 6'd1);
    run_case("open_white", start_b, 5, 3, 1'b0, 64'd1 << 28, 6'd1);
    run_case("corner",     start_b, 0, 0, 1'b1, 64'd0, 6'd0);

    // Occupied origin: done exactly three edges after the enable is seen.
    start_check(start_b, 3, 3, 1'b1);
    wait_done("occupied", cyc);
    check("occupied_latency", 64'(cyc), 64'd3);
    finish_check("occupied", 64'd0, 6'd0);

    b = '0;
    for (int x = 1; x < 8; x++) b = put(b, x, 0, WHT);
    run_case("unclosed", b, 0, 0, 1'b1, 64'd0, 6'd0);
    b = put(b, 7, 0, BLK);
    run_case("edge_close", b, 0, 0, 1'b1, 64'h7E, 6'd6);

    // A wrapping implementation would step from (7,2) to (0,2) and close on (1,2).
    b = '0;
    b = put(b, 0, 2, WHT);
    b = put(b, 1, 2, BLK);
    run_case("no_wrap", b, 7, 2, 1'b1, 64'd0, 6'd0);

    b = '0;
    b = put(b, 1, 0, WHT);
    b = put(b, 2, 0, BAD);
    run_case("code11_empty", b, 0, 0, 1'b1, 64'd0, 6'd0);

    b = '0;
    b = put(b, 4, 3, WHT);
    b = put(b, 5, 3, BLK);
    b = put(b, 3, 4, WHT);
    b = put(b, 3, 5, WHT);
    b = put(b, 3, 6, BLK);
    b = put(b, 4, 4, WHT);
    b = put(b, 5, 5, BLK);
    run_case("multi_dir", b, 3, 3, 1'b1,
             (64'd1 << 28) | (64'd1 << 35) | (64'd1 << 43) | (64'd1 << 36), 6'd4);

    // Abort: the east flip has landed by the sixth edge, then the enable drops.
    start_check(start_b, 2, 3, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("abort_pre_mask", mc_if.flip_mask, 64'd1 << 27);
    mc_if.check_en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mask",  mc_if.flip_mask, 64'd0);
    check("abort_valid", 64'(mc_if.valid_move), 64'd0);
    check("abort_count", 64'(mc_if.flip_count), 64'd0);
    repeat (70) @(posedge clk);
    #1;
    check("abort_done", 64'(mc_if.done), 64'd0);

    // Asynchronous reset between clock edges.
    start_check(start_b, 2, 3, 1'b1);
    repeat (5) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("areset_mask",  mc_if.flip_mask, 64'd0);
    check("areset_done",  64'(mc_if.done), 64'd0);
    check("areset_valid", 64'(mc_if.valid_move), 64'd0);
    mc_if.check_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_case("after_reset", start_b, 2, 3, 1'b1, 64'd1 << 27, 6'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
